// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit: one outstanding request, bridged onto AXI-lite style AR/R/AW/W/B channels.
// Optional alignment check enabled by defining YSYX_25040109_LSU_ALIGN_CHK_EN.
module ysyx_25040109_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dmem_araddr,
  output logic        dmem_arvalid,
  input  logic        dmem_arready,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        dmem_rready,
  input  logic [1:0]  dmem_rresp,
  output logic [31:0] dmem_awaddr,
  output logic        dmem_awvalid,
  input  logic        dmem_awready,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  output logic        dmem_wvalid,
  input  logic        dmem_wready,
  input  logic [1:0]  dmem_bresp,
  input  logic        dmem_bvalid,
  output logic        dmem_bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_AR, S_RD_R, S_WR_AW_W, S_WR_B, S_RSP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        misalign;
  logic        bad_req;
  logic [31:0] load_ext;
  logic [3:0]  size_mask;

  always_comb begin
`ifdef YSYX_25040109_LSU_ALIGN_CHK_EN
    misalign = ((req_size == 2'd1) && req_addr[0]) ||
               ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    bad_req = (req_size == 2'd3) || misalign;
  end

  always_comb begin
    case (size_q)
      2'd0:    load_ext = {{24{~uns_q & dmem_rdata[7]}},  dmem_rdata[7:0]};
      2'd1:    load_ext = {{16{~uns_q & dmem_rdata[15]}}, dmem_rdata[15:0]};
      default: load_ext = dmem_rdata;
    endcase
    case (size_q)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    dmem_arvalid = 1'b0;
    dmem_rready  = 1'b0;
    dmem_awvalid = 1'b0;
    dmem_wvalid  = 1'b0;
    dmem_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          size_d    = req_size;
          uns_d     = req_unsigned;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = bad_req;
          if (bad_req)      state_d = S_RSP;
          else if (req_wen) state_d = S_WR_AW_W;
          else              state_d = S_RD_AR;
        end
      end
      S_RD_AR: begin
        dmem_arvalid = 1'b1;
        if (dmem_arready) state_d = S_RD_R;
      end
      S_RD_R: begin
        dmem_rready = 1'b1;
        if (dmem_rvalid) begin
          err_d   = (dmem_rresp != 2'b00);
          rdata_d = (dmem_rresp != 2'b00) ? '0 : load_ext;
          state_d = S_RSP;
        end
      end
      S_WR_AW_W: begin
        // AW and W retire independently; leave once both have handshaken.
        dmem_awvalid = ~aw_done_q;
        dmem_wvalid  = ~w_done_q;
        aw_done_d    = aw_done_q | dmem_awready;
        w_done_d     = w_done_q | dmem_wready;
        if (aw_done_d && w_done_d) state_d = S_WR_B;
      end
      S_WR_B: begin
        dmem_bready = 1'b1;
        if (dmem_bvalid) begin
          err_d   = (dmem_bresp != 2'b00);
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign rsp_rdata   = (state_q == S_RSP) ? rdata_q : '0;
  assign rsp_err     = (state_q == S_RSP) ? err_q : 1'b0;
  assign dmem_araddr = addr_q;
  assign dmem_awaddr = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_wstrb  = size_mask << addr_q[1:0];

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Randomized bench for ysyx_25040109_lsu with a channel-level slave and a result reference model.
module tb_ysyx_25040109_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] dmem_araddr, dmem_rdata, dmem_awaddr, dmem_wdata;
  logic        dmem_arvalid, dmem_arready, dmem_rvalid, dmem_rready;
  logic [1:0]  dmem_rresp, dmem_bresp;
  logic        dmem_awvalid, dmem_awready, dmem_wvalid, dmem_wready;
  logic        dmem_bvalid, dmem_bready;
  logic [3:0]  dmem_wstrb;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  ysyx_25040109_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dmem_araddr(dmem_araddr), .dmem_arvalid(dmem_arvalid), .dmem_arready(dmem_arready),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .dmem_rready(dmem_rready),
    .dmem_rresp(dmem_rresp), .dmem_awaddr(dmem_awaddr), .dmem_awvalid(dmem_awvalid),
    .dmem_awready(dmem_awready), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_wvalid(dmem_wvalid), .dmem_wready(dmem_wready), .dmem_bresp(dmem_bresp),
    .dmem_bvalid(dmem_bvalid), .dmem_bready(dmem_bready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_local_err(input bit [1:0] size, input bit [31:0] addr);
    bit mis;
    mis = 1'b0;
`ifdef YSYX_25040109_LSU_ALIGN_CHK_EN
    mis = (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
`endif
    return (size == 3) || mis;
  endfunction

  function automatic void ref_result(input bit wen, input bit [1:0] size, input bit uns,
                                     input bit [31:0] addr, input bit [31:0] rdata,
                                     input bit [1:0] rresp, input bit [1:0] bresp,
                                     output logic [31:0] data, output logic err);
    longint v, span;
    data = 0;
    err  = 0;
    if (is_local_err(size, addr)) err = 1;
    else if (wen) err = (bresp != 0);
    else if (rresp != 0) err = 1;
    else begin
      span = longint'(1) << (8 * (1 << size));
      v = longint'(rdata) % span;
      if (!uns && size < 2 && v >= span / 2) v = v - span;
      data = v[31:0];
    end
  endfunction

  task automatic clear_slave();
    dmem_arready = 0; dmem_rvalid = 0; dmem_rdata = 0; dmem_rresp = 0;
    dmem_awready = 0; dmem_wready = 0; dmem_bvalid = 0; dmem_bresp = 0;
    rsp_ready = 0;
  endtask

  task automatic run_txn(input bit wen, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata,
                         input bit [31:0] rdata, input bit [1:0] rresp, input bit [1:0] bresp,
                         input int d_ar, input int d_r, input int d_aw, input int d_w,
                         input int d_b, input int d_rsp, input bit chk_lat);
    logic [31:0] exp_data;
    logic        exp_err;
    bit lerr, ar_done, r_done, aw_done, w_done, b_done, rsp_done;
    bit ar_hit, r_hit, aw_hit, w_hit, b_hit, rsp_hit;
    int c_ar, c_r, c_aw, c_w, c_b, c_rsp, cyc, first_rsp;
    int exp_strb;
    ref_result(wen, size, uns, addr, rdata, rresp, bresp, exp_data, exp_err);
    lerr = is_local_err(size, addr);
    exp_strb = (((1 << (1 << size)) - 1) << (addr % 4)) & 'hF;
    {ar_done, r_done, aw_done, w_done, b_done, rsp_done} = '0;
    {c_ar, c_r, c_aw, c_w, c_b, c_rsp} = '0;
    first_rsp = 0;
    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    cyc = 1;
    while (!rsp_done && cyc < 200) begin
      clear_slave();
      {ar_hit, r_hit, aw_hit, w_hit, b_hit, rsp_hit} = '0;
      check_eq("arvalid", 32'(dmem_arvalid), 32'(!wen && !lerr && !ar_done));
      check_eq("rready", 32'(dmem_rready), 32'(ar_done && !r_done));
      check_eq("awvalid", 32'(dmem_awvalid), 32'(wen && !lerr && !aw_done));
      check_eq("wvalid", 32'(dmem_wvalid), 32'(wen && !lerr && !w_done));
      check_eq("bready", 32'(dmem_bready), 32'(aw_done && w_done && !b_done));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(lerr || r_done || b_done));
      check_eq("req_ready_busy", 32'(req_ready), 0);
      if (dmem_arvalid) begin
        check_eq("araddr", dmem_araddr, addr);
        dmem_arready = (c_ar >= d_ar); ar_hit = dmem_arready; c_ar++;
      end
      if (dmem_rready) begin
        dmem_rvalid = (c_r >= d_r); r_hit = dmem_rvalid; c_r++;
        dmem_rdata = r_hit ? rdata : $urandom;
        dmem_rresp = r_hit ? rresp : 2'($urandom);
      end
      if (dmem_awvalid) begin
        check_eq("awaddr", dmem_awaddr, addr);
        dmem_awready = (c_aw >= d_aw); aw_hit = dmem_awready; c_aw++;
      end
      if (dmem_wvalid) begin
        check_eq("wdata", dmem_wdata, wdata);
        check_eq("wstrb", 32'(dmem_wstrb), 32'(exp_strb));
        dmem_wready = (c_w >= d_w); w_hit = dmem_wready; c_w++;
      end
      if (dmem_bready) begin
        dmem_bvalid = (c_b >= d_b); b_hit = dmem_bvalid; c_b++;
        dmem_bresp = b_hit ? bresp : 2'($urandom);
      end
      if (rsp_valid) begin
        if (first_rsp == 0) first_rsp = cyc;
        check_eq("rsp_rdata", rsp_rdata, exp_data);
        check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
        rsp_ready = (c_rsp >= d_rsp); rsp_hit = rsp_ready; c_rsp++;
      end
      @(negedge clk);
      ar_done |= ar_hit; r_done |= r_hit; aw_done |= aw_hit;
      w_done |= w_hit; b_done |= b_hit; rsp_done |= rsp_hit;
      cyc++;
    end
    clear_slave();
    check_eq("rsp_done_in_budget", 32'(rsp_done), 1);
    check_eq("rsp_hold_cycles", 32'(c_rsp), 32'(d_rsp + 1));
    check_eq("req_ready_after_rsp", 32'(req_ready), 1);
    check_eq("rsp_valid_after_rsp", 32'(rsp_valid), 0);
    if (chk_lat) check_eq("latency", 32'(first_rsp), lerr ? 1 : 3);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_wen = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    clear_slave();
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_err", 32'(rsp_err), 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_bus_valids", 32'({dmem_arvalid, dmem_awvalid, dmem_wvalid, dmem_rready, dmem_bready}), 0);
    rst = 0;

    // byte loads, signed and unsigned, zero-wait with latency check
    run_txn(0, 0, 0, 32'h80000003, 0, 32'h000000F0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_txn(0, 0, 1, 32'h80000003, 0, 32'h000000F0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // half store, zero-wait
    run_txn(1, 1, 0, 32'h80000002, 32'h1234ABCD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // AW stalled three cycles while W completes first
    run_txn(1, 2, 0, 32'h80000008, 32'hCAFEF00D, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0);
    // W stalled while AW completes first
    run_txn(1, 0, 0, 32'h80000005, 32'h000000AA, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    // read error held under back-pressure
    run_txn(0, 2, 0, 32'h80000010, 0, 32'hDEADBEEF, 2'b10, 0, 1, 1, 0, 0, 0, 4, 0);
    // store bus error
    run_txn(1, 2, 0, 32'h80000014, 32'h55AA55AA, 0, 0, 2'b11, 0, 0, 0, 0, 2, 1, 0);
    // misaligned word load (local error only when alignment check is built in)
    run_txn(0, 2, 0, 32'h80000001, 0, 32'h87654321, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // illegal size
    run_txn(0, 3, 0, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_txn(1, 3, 0, 32'h80000004, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    // half loads with sign bit 15
    run_txn(0, 1, 0, 32'h80000020, 0, 32'h12348001, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    run_txn(0, 1, 1, 32'h80000020, 0, 32'h12348001, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // reset while waiting for R data
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_size = 2; req_unsigned = 0; req_addr = 32'h80000040;
    @(negedge clk);
    req_valid = 0;
    check_eq("rstmid_arvalid", 32'(dmem_arvalid), 1);
    dmem_arready = 1;
    @(negedge clk);
    dmem_arready = 0;
    check_eq("rstmid_rready_before", 32'(dmem_rready), 1);
    rst = 1;
    @(negedge clk);
    check_eq("rstmid_rready", 32'(dmem_rready), 0);
    check_eq("rstmid_arvalid_off", 32'(dmem_arvalid), 0);
    check_eq("rstmid_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rstmid_rsp_err", 32'(rsp_err), 0);
    check_eq("rstmid_rsp_rdata", rsp_rdata, 0);
    rst = 0;
    @(negedge clk);
    check_eq("rstmid_req_ready", 32'(req_ready), 1);

    for (int i = 0; i < 60; i++) begin
      bit [1:0] sz;
      int d[6];
      bit zero;
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      zero = 1;
      for (int k = 0; k < 6; k++) begin
        d[k] = ($urandom % 2 == 0) ? 0 : $urandom_range(0, 3);
        if (d[k] != 0) zero = 0;
      end
      run_txn(1'($urandom), sz, 1'($urandom), 32'h80000000 | ($urandom & 32'hFFFF),
              $urandom, $urandom,
              ($urandom % 5 == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              ($urandom % 5 == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              d[0], d[1], d[2], d[3], d[4], d[5], zero);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
